// File: rtl/dm_unit.sv
// dm_unit: MEM-stage data memory with byte-lane stores, extended loads, fault
// classification and a post-reset hardware clear of the whole array.
module dm_unit #(
    parameter int          DEPTH       = 4096,
    parameter logic [31:0] TIMER0_BASE = 32'h0000_7f00,
    parameter logic [31:0] TIMER1_BASE = 32'h0000_7f10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_exc,
    output logic [31:0] rsp_pc,
    output logic        init_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_mem [DEPTH];

    logic          w_acc, w_word, w_half, w_mis, w_tmr, w_dm, w_ro, w_fault, w_wr, w_rd;
    logic [AW-1:0] w_widx;
    logic [31:0]   w_rword, w_sh, w_ext, w_wd;
    logic [3:0]    w_be;

    assign req_ready = (r_state == ST_RUN);
    assign init_busy = ~req_ready;
    assign w_acc     = req_valid & req_ready;
    assign w_word    = req_size[1];
    assign w_half    = (req_size == 2'b01);
    assign w_mis     = (w_word & (req_addr[1:0] != 2'b00)) | (w_half & req_addr[0]);
    assign w_tmr     = ((req_addr - TIMER0_BASE) < 32'd12) | ((req_addr - TIMER1_BASE) < 32'd12);
    assign w_dm      = ((req_addr >> (AW + 2)) == 32'd0);
    assign w_ro      = req_we & w_word &
                       ((req_addr == TIMER0_BASE + 32'd8) | (req_addr == TIMER1_BASE + 32'd8));
    assign w_fault   = w_mis | (w_tmr & ~w_word) | (~w_tmr & ~w_dm) | w_ro;
    // Non-faulting, non-timer accesses are guaranteed to hit the DM region.
    assign w_wr      = w_acc & req_we & ~w_fault & ~w_tmr;
    assign w_rd      = ~req_we & ~w_fault & ~w_tmr;
    assign w_widx    = req_addr[AW+1:2];
    assign w_rword   = r_mem[w_widx];
    assign w_sh      = w_rword >> {req_addr[1:0], 3'b000};
    assign w_ext     = w_word ? w_rword :
                       w_half ? {{16{~req_unsigned & w_sh[15]}}, w_sh[15:0]} :
                                {{24{~req_unsigned & w_sh[7]}}, w_sh[7:0]};
    assign w_be      = w_word ? 4'hf : w_half ? (req_addr[1] ? 4'hc : 4'h3) : 4'b0001 << req_addr[1:0];
    assign w_wd      = w_word ? req_wdata : w_half ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};

    // Array has no reset; the INIT sweep is what guarantees zero contents.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT)
            r_mem[r_idx] <= '0;
        else if (w_wr)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wd[8*b +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else if (r_state == ST_INIT) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == AW'(DEPTH - 1)) r_state <= ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_exc   <= '0;
            rsp_pc    <= '0;
        end else begin
            rsp_valid <= w_acc;
            if (w_acc) begin
                rsp_rdata <= w_rd ? w_ext : 32'd0;
                rsp_exc   <= w_fault ? (req_we ? 5'd5 : 5'd4) : 5'd0;
                rsp_pc    <= req_pc;
            end
        end
    end
endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: randomized scoreboard bench for dm_unit against a byte-array
// reference model; covers clear sequence, extension, faults and resets.
module tb_dm_unit;
    localparam int          DEPTH = 16;
    localparam logic [31:0] T0    = 32'h0000_7f00;
    localparam logic [31:0] T1    = 32'h0000_7f10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic        req_ready, rsp_valid, init_busy;
    logic [31:0] rsp_rdata, rsp_pc;
    logic [4:0]  rsp_exc;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  exc;
        logic [31:0] pc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem_m [4*DEPTH];
    logic [31:0] pc_n = 32'h0040_0000;
    int          total = 0;
    int          bad = 0;

    dm_unit #(.DEPTH(DEPTH), .TIMER0_BASE(T0), .TIMER1_BASE(T1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc),
        .rsp_pc(rsp_pc), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, x);
        end
    endfunction

    // Reference: memory as a flat byte array, little-endian, faults by rule order.
    function automatic void model(input bit we, input logic [1:0] s, input bit uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic [4:0] ex);
        int          n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        bit          tm = (a >= T0 && a < T0 + 12) || (a >= T1 && a < T1 + 12);
        bit          dm = a < 4 * DEPTH;
        bit          f;
        logic [31:0] v = '0;
        f = (a % n != 0) || (tm && n < 4) || (!dm && !tm) || (we && n == 4 && (a == T0 + 8 || a == T1 + 8));
        rd = '0;
        ex = f ? (we ? 5'd5 : 5'd4) : 5'd0;
        if (f || tm) return;
        if (we) begin
            for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[a + i];
            if (n == 1)      rd = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            else if (n == 2) rd = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else             rd = v;
        end
    endfunction

    task automatic set_req(input bit we, input logic [1:0] s, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r;
        logic [4:0]  e;
        req_we = we; req_size = s; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_pc = pc_n; req_valid = 1'b1;
        model(we, s, uns, a, wd, r, e);
        q.push_back('{r, e, pc_n});
        pc_n += 4;
    endtask

    task automatic issue(input bit we, input logic [1:0] s, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        set_req(we, s, uns, a, wd);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4 * DEPTH; i++) mem_m[i] = 8'h00;
    endtask

    // Releases reset and expects exactly DEPTH not-ready cycles with no responses.
    task automatic release_and_count(input string tag);
        int n = 0;
        bit spurious = 0;
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) spurious = 1;
            if (req_ready) break;
            if (!init_busy) spurious = 1;
            n++;
        end
        chk({tag, "_clear_cycles"}, n, DEPTH);
        chk({tag, "_quiet"}, {31'd0, spurious}, 32'd0);
        clear_model();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected pc=%h", rsp_pc);
            end else begin
                e = q.pop_front();
                chk("rdata", rsp_rdata, e.rdata);
                chk("exc", {27'd0, rsp_exc}, {27'd0, e.exc});
                chk("pc", rsp_pc, e.pc);
            end
        end
    end

    initial begin
        logic v1, v2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, init_busy}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_exc", {27'd0, rsp_exc}, 32'd0);
        chk("rst_pc", rsp_pc, 32'd0);
        @(posedge clk); #1;
        release_and_count("init");
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) issue(0, 2'd2, 0, 32'(4 * i), 0);

        issue(1, 2'd2, 0, 32'h8, 32'h1234_5678);
        issue(1, 2'd0, 0, 32'h9, 32'h0000_00AB);
        issue(0, 2'd0, 0, 32'h9, 0);
        issue(0, 2'd0, 1, 32'h9, 0);
        issue(0, 2'd2, 0, 32'h8, 0);
        issue(1, 2'd1, 0, 32'h6, 32'h0000_8001);

        set_req(0, 2'd1, 0, 32'h6, 0);
        @(posedge clk); #1;
        set_req(0, 2'd1, 1, 32'h6, 0);
        @(negedge clk); v1 = rsp_valid;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); v2 = rsp_valid;
        chk("b2b_valid", {30'd0, v1, v2}, 32'd3);

        @(posedge clk); #1;
        issue(1, 2'd2, 0, 32'h0, 32'hCAFE_F00D);
        issue(0, 2'd2, 0, 32'h2, 0);
        issue(1, 2'd1, 0, 32'h3, 32'h0000_1111);
        issue(0, 2'd2, 0, 32'h0, 0);
        issue(0, 2'd0, 0, 32'h7f04, 0);
        issue(1, 2'd2, 0, 32'h7f18, 32'h5);
        issue(1, 2'd2, 0, 32'h7f10, 32'h5);
        issue(0, 2'd2, 0, 32'h7f08, 0);
        issue(0, 2'd2, 0, 32'h10000, 0);
        issue(1, 2'd3, 0, 32'h3c, 32'h8765_4321);
        issue(0, 2'd3, 0, 32'h3c, 0);

        for (int i = 0; i < 32; i++) begin
            logic [1:0] s = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom_range(0, 4 * DEPTH - 1);
            a = (s == 2'd0) ? a : (s == 2'd1) ? (a & ~32'd1) : (a & ~32'd3);
            set_req(1, s, 0, a, $urandom);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 32; i++) begin
            logic [1:0] s = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom_range(0, 4 * DEPTH - 1);
            a = (s == 2'd0) ? a : (s == 2'd1) ? (a & ~32'd1) : (a & ~32'd3);
            set_req(0, s, 1'($urandom), a, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 60; i++) begin
            int k = $urandom_range(0, 3);
            logic [31:0] a = (k == 0) ? T0 + $urandom_range(0, 15) :
                             (k == 1) ? T1 + $urandom_range(0, 15) :
                             (k == 2) ? $urandom : $urandom_range(0, 4 * DEPTH + 7);
            set_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        @(posedge clk); #1;
        issue(0, 2'd2, 0, 32'h8, 0);
        chk("pend_valid", {31'd0, rsp_valid}, 32'd1);
        #1 reset = 1'b0;
        #1 chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
        void'(q.pop_back());
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("midclear_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midclear_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        release_and_count("reclear");
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) issue(0, 2'd2, 0, 32'(4 * i), 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        chk("final_drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dm_unit.md
# dm_unit

Parametrised, pipelined data-memory unit for the MIPS pipeline's MEM stage. It accepts one load/store request per cycle over a valid/ready handshake and performs byte-lane writes. Loads return sign/zero-extended data with one cycle of latency. The unit classifies alignment and address-space exceptions (ExcCode 4 for load faults, 5 for store faults). After reset it runs a hardware clear sequence before accepting traffic.

## Interface
- DEPTH, 4096: number of 32-bit words; must be a power of 2 and ≥ 2.
- TIMER0_BASE, 32'h0000_7f00: base of timer 0 register window (3 words).
- TIMER1_BASE, 32'h0000_7f10: base of timer 1 register window (3 words).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  in  32  PC of the instruction, carried to the response.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores, faults and timer hits.
- rsp_exc  out  5  0 none, 4 load fault, 5 store fault.
- rsp_pc  out  32  req_pc of the responding request.
- init_busy  out  1  high while the clear sequence runs.

## Operation
- States:
  - INIT: writes 0 to word idx, then increments idx; a log2(DEPTH)-bit counter. Transitions to RUN in the cycle idx == DEPTH-1 is written.
  - RUN: req_ready = 1 and init_busy = 0.
- Accept condition: req_valid & req_ready. No request is accepted in INIT.
- DM region: addresses 0 .. 4*DEPTH-1. The word index is addr[log2(DEPTH)+1:2].
- Timer region: TIMERn_BASE .. TIMERn_BASE+11.
- Any other address is unmapped.
- Fault rules, evaluated in priority order (first match wins):
  1. Misalignment: a word access with addr[1:0] ≠ 0, or a half access with addr[0] ≠ 0.
  2. A byte or half access to a timer region.
  3. An access to an unmapped address.
  4. A word store to TIMERn_BASE+8 (read-only count register).
- Fault code: 4 if req_we = 0, otherwise 5.
- A faulting store does not modify memory. A faulting load returns rdata 0.
- A legal timer access does not touch memory and returns exc 0 with rdata 0; the bridge supplies timer data.
- Store byte enables:
  - byte: lane addr[1:0].
  - half: lanes {addr[1],0}+{1,0}.
  - word: all four lanes.
  - Write data is replicated into the selected lanes.
- Load extraction: select the byte or half by addr[1:0], then sign- or zero-extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Store and load in consecutive cycles to the same word: the load returns the post-store value, because the write commits at the accept edge.

## Timing
- Reset asserted (asynchronously):
  - state = INIT, idx = 0.
  - req_ready = 0, init_busy = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_exc = 0, rsp_pc = 0.
- After reset deassertion the clear takes exactly DEPTH cycles. req_ready rises on the edge after the last clear write.
- Latency: a request accepted at edge N produces rsp_* valid for the cycle after edge N. rsp_valid drops at edge N+1 unless another request is accepted at N+1.
- Throughput: one request per cycle. There is no backpressure on the response side; the consumer must always take it.
- Reset asserted mid-clear or mid-traffic:
  - Any pending response is discarded; rsp_valid = 0 immediately.
  - The clear sequence restarts from idx 0.
- The memory array itself has no reset; contents are guaranteed zero only after INIT completes.

## Test plan
- Reset release, DEPTH = 16: req_ready = 0 for 16 cycles and init_busy = 1. Then req_ready = 1, and lw of every word returns 0.
- sw 0x1234_5678 @0x8; sb 0xAB @0x9; lb @0x9 then lbu @0x9 → rdata 0xFFFF_FFAB, then 0x0000_00AB; lw @0x8 → 0x1234_ABAB... **corrected:** lw @0x8 → 0x1234_AB78.
- sh 0x8001 @0x6; lh @0x6 → 0xFFFF_8001; lhu @0x6 → 0x0000_8001. Back-to-back issue yields rsp_valid high for two consecutive cycles.
- Exception cases:
  - lw @0x2 → exc 4.
  - sh @0x3 → exc 5, and the word at 0x0 is unchanged.
  - lb @0x7f04 → exc 4.
  - sw @0x7f18 → exc 5.
  - sw @0x7f10 → exc 0.
  - lw @0x10000 (with DEPTH = 4096) → exc 4.
- Continuous valid stream of 32 stores then 32 loads: all responses arrive in order, each with rsp_pc matching its request.
- Reset asserted at clear index 7, released 3 cycles later: a full DEPTH-cycle clear reruns and rsp_valid stays 0 throughout.
